point_render_ctrl: RTL and testbench
====================================

# point_render_ctrl

Sequencer that decides whether a display pixel is lit by any entry of a small table of stored points. It time-multiplexes a single `radius_check` instance across the table, one point per cycle, and OR-accumulates the hits. It sits between the host/SPI register path, which writes the point table, and the display scan logic, which issues per-pixel requests over a valid/ready handshake and consumes one lit/unlit result per request.

## Interface
- `NUM_POINTS`, default 4: point table depth, ≥1.
- `COORD_W`, default 4: unsigned coordinate width, ≤15.
- `clock`  in  1: single clock, all logic on posedge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `wr_en`  in  1: point table write strobe.
- `wr_idx`  in  $clog2(NUM_POINTS): entry to write.
- `wr_x`, `wr_y`  in  COORD_W each: point coordinates.
- `wr_valid`  in  1: entry enable bit to store (0 disables the entry).
- `req_valid`  in  1: pixel request present.
- `req_x`, `req_y`  in  COORD_W each: pixel coordinates.
- `req_ready`  out  1: controller can accept a request.
- `pix_valid`  out  1: one-cycle result strobe.
- `pix_on`  out  1: result, held until the next `pix_valid`.
- `busy`  out  1: scan in progress (state ≠ IDLE).

## Operation
- FSM states: IDLE, SCAN, DONE.
  - IDLE: `req_ready`=1. When `req_valid`&&`req_ready`, latch `req_x`/`req_y`, set idx=0, clear acc, go to SCAN.
  - SCAN: check entry idx. A hit requires entry valid && `radius_check` valid. acc |= hit. If idx==NUM_POINTS-1, go to DONE; else idx++.
  - DONE: `pix_valid`=1, `pix_on`=acc. Go to IDLE.
- Coordinate arithmetic:
  - Coordinates are zero-extended to 16-bit signed before the subtraction in `radius_check`, so differences are signed.
  - No wrap-around: (0,0) vs (15,0) is dx=15, which is a miss.
- `radius_check` uses its default shape: the 3×3 block plus the four axial radius-2 pixels.
- Point table writes:
  - Accepted in any state; they take effect the next cycle.
  - A SCAN cycle reading the entry being written in that same cycle uses the old value.
- Reset (any state, including mid-scan):
  - Asynchronously forces IDLE, idx=0, acc=0.
  - All table entries become invalid (coordinates 0).
  - `pix_valid`=0, `pix_on`=0, `busy`=0.
  - `req_ready`=1 once reset is deasserted.

## Timing
- Accept at cycle T. Entry k is checked at T+1+k. DONE, and therefore `pix_valid`, occurs at T+1+NUM_POINTS.
- IDLE resumes at T+2+NUM_POINTS, so the next accept is possible that cycle.
- Throughput: one request per NUM_POINTS+2 cycles.
- `req_ready` is a combinational decode of the state register; there are no combinational paths from `req_*` to any output.
- `pix_on` is registered and stable between strobes.

## Configuration
- `POINT_RENDER_EARLY_EXIT_EN`:
  - Defined: SCAN goes to DONE in the cycle after the first hit. A hit at entry k gives `pix_valid` at T+2+k.
  - Undefined: all entries are always scanned and latency is fixed at NUM_POINTS+1.
- `pix_on` values are identical in both builds.

## Structure
- Shared package `render_pkg`:
  - `coord_t` (logic [COORD_W-1:0]).
  - `point_t` struct {valid, x, y}.
  - FSM state enum `render_state_e`.
- Sub-module `point_table`: register array of `point_t` with async-reset clear, one write port, and one combinational read port indexed by idx.
- Top-level instances: the FSM, `point_table`, and the existing `radius_check`.

## Test plan
All scenarios use NUM_POINTS=4, COORD_W=4.
- After reset, with an empty table, request (5,5) -> `pix_valid` at T+5 with `pix_on`=0; `req_ready`=1 at T+6.
- Write entry 0 = (5,5) valid:
  - Request (6,6) -> `pix_on`=1 (diagonal).
  - Request (7,6) -> `pix_on`=0 (dx=2, dy=1 is off).
  - Request (5,7) -> `pix_on`=1 (axial radius 2).
- Write entry 3 = (0,0) valid, request (15,0) -> `pix_on`=0 (no wrap).
- Disable entry 3 with `wr_valid`=0, request (0,0) -> `pix_on`=0.
- Early exit: with entry 0 = (5,5) valid, request (5,5):
  - With `POINT_RENDER_EARLY_EXIT_EN`: `pix_valid` at T+2.
  - Without it: `pix_valid` at T+5, `pix_on`=1 in both builds.
- Same-cycle write and mid-scan reset:
  - Overwrite entry 1 in its own SCAN cycle (T+2) -> the old value decides the result.
  - Assert `reset_n` low at T+3 -> `busy`=0 and `pix_valid`=0 immediately, the table is invalid, and no stray `pix_valid` follows.

Source files
------------

// File: rtl/render_pkg.sv
// Shared types for the point renderer: point-table entry, coordinate type and FSM states.
// coord_t is sized for the widest supported coordinate; narrower coordinates are zero-extended.
package render_pkg;

  localparam int unsigned CoordMaxW = 15;

  typedef logic [CoordMaxW-1:0] coord_t;

  typedef struct packed {
    logic   valid;
    coord_t x;
    coord_t y;
  } point_t;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } render_state_e;

  function automatic point_t make_point(logic valid, coord_t x, coord_t y);
    point_t p;
    p.valid = valid;
    p.x     = x;
    p.y     = y;
    return p;
  endfunction

endpackage

// File: rtl/point_table.sv
// Register array of points: async clear to all-invalid, one write port, one combinational
// read port. A read of the entry being written in the same cycle returns the old value.
module point_table
  import render_pkg::*;
#(
  parameter int unsigned NUM_POINTS = 4,
  parameter int unsigned IDX_W      = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  point_t           wr_point,
  input  logic [IDX_W-1:0] rd_idx,
  output point_t           rd_point
);

  point_t entries_q [NUM_POINTS];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_POINTS); i++) begin
        entries_q[i] <= '0;
      end
    end else if (wr_en && (32'(wr_idx) < NUM_POINTS)) begin
      entries_q[wr_idx] <= wr_point;
    end
  end

  // Out-of-range indices (non power-of-two depth) read as an invalid entry.
  always_comb begin
    rd_point = '0;
    if (32'(rd_idx) < NUM_POINTS) begin
      rd_point = entries_q[rd_idx];
    end
  end

endmodule

// File: rtl/radius_check.sv
// Combinational proximity test: is pixel (pix_x, pix_y) inside the 3x3 block around the
// centre, optionally extended by the four axial radius-2 pixels (default shape).
module radius_check #(
  parameter int unsigned COORD_W  = 4,
  parameter bit          AXIAL_R2 = 1'b1
) (
  input  logic [COORD_W-1:0] center_x,
  input  logic [COORD_W-1:0] center_y,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  output logic               valid
);

  logic signed [15:0] dx, dy;
  logic        [15:0] adx, ady;
  logic               in_block, in_axial;

  // Zero-extend to 16 bits before subtracting so differences are signed and never wrap.
  always_comb begin
    dx       = signed'(16'(pix_x)) - signed'(16'(center_x));
    dy       = signed'(16'(pix_y)) - signed'(16'(center_y));
    adx      = dx[15] ? 16'(-dx) : 16'(dx);
    ady      = dy[15] ? 16'(-dy) : 16'(dy);
    in_block = (adx <= 16'd1) && (ady <= 16'd1);
    in_axial = AXIAL_R2 && (((adx == 16'd2) && (ady == 16'd0)) ||
                            ((adx == 16'd0) && (ady == 16'd2)));
    valid    = in_block || in_axial;
  end

endmodule

// File: rtl/point_render_ctrl.sv
// Pixel-lit sequencer: scans the point table one entry per cycle through a shared
// radius_check and OR-accumulates hits. Define POINT_RENDER_EARLY_EXIT_EN to stop at first hit.
module point_render_ctrl
  import render_pkg::*;
#(
  parameter  int unsigned NUM_POINTS = 4,
  parameter  int unsigned COORD_W    = 4,
  localparam int unsigned IDX_W      = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic               wr_valid,
  input  logic               req_valid,
  input  logic [COORD_W-1:0] req_x,
  input  logic [COORD_W-1:0] req_y,
  output logic               req_ready,
  output logic               pix_valid,
  output logic               pix_on,
  output logic               busy
);

  render_state_e    state_q;
  logic [IDX_W-1:0] idx_q;
  logic             acc_q;
  logic             pix_valid_q;
  logic             pix_on_q;
  coord_t           req_x_q, req_y_q;

  point_t           wr_point;
  point_t           entry;
  logic             rc_valid;
  logic             hit;
  logic             last_idx;
  logic             scan_end;

  assign wr_point = make_point(wr_valid, coord_t'(wr_x), coord_t'(wr_y));

  point_table #(
    .NUM_POINTS (NUM_POINTS),
    .IDX_W      (IDX_W)
  ) u_point_table (
    .clock    (clock),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_point (wr_point),
    .rd_idx   (idx_q),
    .rd_point (entry)
  );

  // Coordinates are already zero-extended to coord_t, so the check runs at full width.
  radius_check #(
    .COORD_W  (CoordMaxW),
    .AXIAL_R2 (1'b1)
  ) u_radius_check (
    .center_x (entry.x),
    .center_y (entry.y),
    .pix_x    (req_x_q),
    .pix_y    (req_y_q),
    .valid    (rc_valid)
  );

  assign hit      = entry.valid && rc_valid;
  assign last_idx = (idx_q == IDX_W'(NUM_POINTS - 1));

`ifdef POINT_RENDER_EARLY_EXIT_EN
  assign scan_end = last_idx || hit;
`else
  assign scan_end = last_idx;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      acc_q       <= 1'b0;
      req_x_q     <= '0;
      req_y_q     <= '0;
      pix_valid_q <= 1'b0;
      pix_on_q    <= 1'b0;
    end else begin
      pix_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            req_x_q <= coord_t'(req_x);
            req_y_q <= coord_t'(req_y);
            idx_q   <= '0;
            acc_q   <= 1'b0;
            state_q <= StScan;
          end
        end
        StScan: begin
          acc_q <= acc_q || hit;
          if (scan_end) begin
            // Result registers load on entry to DONE so they are valid during that cycle.
            pix_valid_q <= 1'b1;
            pix_on_q    <= acc_q || hit;
            state_q     <= StDone;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign pix_valid = pix_valid_q;
  assign pix_on    = pix_on_q;

endmodule

// File: tb/tb_point_render_ctrl.sv
// Scoreboard bench for point_render_ctrl: directed scenarios plus randomized table writes and
// pixel requests, predicted from a geometric model of the lit region around each point.
module tb_point_render_ctrl;

  localparam int unsigned NumPoints = 4;
  localparam int unsigned CoordW    = 4;
`ifdef POINT_RENDER_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  logic              clock     = 1'b0;
  logic              reset_n   = 1'b0;
  logic              wr_en     = 1'b0;
  logic [1:0]        wr_idx    = '0;
  logic [CoordW-1:0] wr_x      = '0;
  logic [CoordW-1:0] wr_y      = '0;
  logic              wr_valid  = 1'b0;
  logic              req_valid = 1'b0;
  logic [CoordW-1:0] req_x     = '0;
  logic [CoordW-1:0] req_y     = '0;
  logic              req_ready, pix_valid, pix_on, busy;

  point_render_ctrl #(
    .NUM_POINTS (NumPoints),
    .COORD_W    (CoordW)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_valid  (wr_valid),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ready (req_ready),
    .pix_valid (pix_valid),
    .pix_on    (pix_on),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference model: the point table as the host believes it to be.
  bit m_valid [NumPoints];
  int m_x     [NumPoints];
  int m_y     [NumPoints];

  typedef struct {
    bit          on;
    int unsigned due;
  } exp_t;

  exp_t sb[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  bit   last_on = 1'b0;

  task automatic check(string name, int got, int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Lit region: every pixel within one step (including diagonals), plus two steps straight
  // along an axis. Plain integer distances, so nothing wraps at the screen edge.
  function automatic bit covers(int cx, int cy, int px, int py);
    int adx, ady;
    adx = (px > cx) ? px - cx : cx - px;
    ady = (py > cy) ? py - cy : cy - py;
    return ((adx <= 1) && (ady <= 1)) || ((adx + ady == 2) && (adx == 0 || ady == 0));
  endfunction

  function automatic exp_t predict(int px, int py, int unsigned t);
    exp_t e;
    int   first = -1;
    e.on = 1'b0;
    for (int k = 0; k < int'(NumPoints); k++) begin
      if (m_valid[k] && covers(m_x[k], m_y[k], px, py)) begin
        e.on = 1'b1;
        if (first < 0) first = k;
      end
    end
    e.due = (EarlyExit && e.on) ? t + 2 + int'(first) : t + 1 + NumPoints;
    return e;
  endfunction

  // Monitor: pops one expectation per strobe and checks that pix_on holds between strobes.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset_n) begin
      if (pix_valid) begin
        if (sb.size() == 0) begin
          check("stray pix_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("pix_on", int'(pix_on), int'(e.on));
          check("pix_valid cycle", int'(cyc), int'(e.due));
          last_on = e.on;
        end
      end else begin
        check("pix_on hold", int'(pix_on), int'(last_on));
        if (sb.size() > 0 && cyc > sb[0].due) begin
          check("missing pix_valid", 0, 1);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic write_point(int idx, int x, int y, bit v);
    @(negedge clock);
    wr_en    = 1'b1;
    wr_idx   = idx[1:0];
    wr_x     = x[CoordW-1:0];
    wr_y     = y[CoordW-1:0];
    wr_valid = v;
    @(posedge clock);
    #1;
    wr_en      = 1'b0;
    m_valid[idx] = v;
    m_x[idx]     = x;
    m_y[idx]     = y;
  endtask

  task automatic start_req(int px, int py, output int unsigned due);
    int   w = 0;
    exp_t e;
    due = 0;
    @(negedge clock);
    while (!req_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    if (!req_ready) begin
      check("req_ready wait", 0, 1);
    end else begin
      req_valid = 1'b1;
      req_x     = px[CoordW-1:0];
      req_y     = py[CoordW-1:0];
      e         = predict(px, py, cyc);
      due       = e.due;
      sb.push_back(e);
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      check("busy after accept", int'(busy), 1);
      check("req_ready after accept", int'(req_ready), 0);
    end
  endtask

  task automatic finish_req(int unsigned due);
    int w = 0;
    @(negedge clock);
    while (!req_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    check("req_ready return cycle", int'(cyc), int'(due + 1));
  endtask

  task automatic do_req(int px, int py);
    int unsigned due;
    start_req(px, py, due);
    finish_req(due);
  endtask

  task automatic clear_model();
    for (int k = 0; k < int'(NumPoints); k++) begin
      m_valid[k] = 1'b0;
      m_x[k]     = 0;
      m_y[k]     = 0;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int unsigned due;
    clear_model();

    // Reset state.
    repeat (3) @(negedge clock);
    check("reset busy", int'(busy), 0);
    check("reset pix_valid", int'(pix_valid), 0);
    check("reset pix_on", int'(pix_on), 0);
    #2 reset_n = 1'b1;
    @(negedge clock);
    check("ready after reset", int'(req_ready), 1);
    check("busy after reset", int'(busy), 0);

    // Empty table.
    do_req(5, 5);

    // Shape around (5,5).
    write_point(0, 5, 5, 1'b1);
    do_req(6, 6);
    do_req(7, 6);
    do_req(5, 7);
    do_req(5, 5);
    do_req(3, 5);
    do_req(7, 7);

    // No wrap-around, then disable.
    write_point(3, 0, 0, 1'b1);
    do_req(15, 0);
    do_req(1, 1);
    write_point(3, 0, 0, 1'b0);
    do_req(0, 0);

    // Overwrite entry 1 during its own scan cycle: the old value decides.
    write_point(0, 5, 5, 1'b0);
    write_point(1, 10, 10, 1'b1);
    start_req(10, 10, due);
    @(posedge clock);
    write_point(1, 0, 0, 1'b1);
    finish_req(due);
    do_req(10, 10);
    do_req(0, 0);

    // Reset in the middle of a scan.
    start_req(8, 8, due);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    sb.delete();
    last_on = 1'b0;
    clear_model();
    #1;
    check("mid-scan reset busy", int'(busy), 0);
    check("mid-scan reset pix_valid", int'(pix_valid), 0);
    check("mid-scan reset pix_on", int'(pix_on), 0);
    @(negedge clock);
    #2 reset_n = 1'b1;
    repeat (10) @(negedge clock);
    check("ready after mid-scan reset", int'(req_ready), 1);
    check("busy after mid-scan reset", int'(busy), 0);
    do_req(0, 0);
    do_req(10, 10);

    // Randomized traffic.
    repeat (200) begin
      if ($urandom_range(0, 2) == 0) begin
        write_point(int'($urandom_range(0, NumPoints - 1)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      end else begin
        do_req(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      end
    end

    repeat (8) @(negedge clock);
    check("outstanding expectations", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
